// File: rtl/bus_mem.sv
// bus_mem: word-addressed register-array memory with a req/ready handshake,
// programmable wait states, out-of-range error flag and a preload port.
module bus_mem #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int DEPTH       = 38,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              err,
   output logic              busy,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data
);

   localparam int              IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]      WS    = 4'(WAIT_STATES);
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

   state_t              state, state_nx;
   logic [3:0]          cnt, cnt_nx;
   logic                lwr, lwr_nx;
   logic [ADDR_W-1:0]   laddr, laddr_nx;
   logic [DATA_W-1:0]   lwdata, lwdata_nx;
   logic [DATA_W-1:0]   rdata_nx;
   logic                err_nx;

   logic                enter_done;
   logic                acc_wr;
   logic [ADDR_W-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_wdata;
   logic                acc_in_range;
   logic                ld_in_range;
   logic [IDX_W-1:0]    acc_idx;

   logic                mem_we;
   logic [IDX_W-1:0]    mem_idx;
   logic [DATA_W-1:0]   mem_wd;
   logic [DATA_W-1:0]   mem [DEPTH];

   assign ready = (state == ST_DONE);
   assign busy  = (state != ST_IDLE);

   // Next-state, request latching, completion data and the single memory write port.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      lwr_nx     = lwr;
      laddr_nx   = laddr;
      lwdata_nx  = lwdata;
      enter_done = 1'b0;
      acc_wr     = lwr;
      acc_addr   = laddr;
      acc_wdata  = lwdata;

      case (state)
         ST_IDLE, ST_DONE: begin
            state_nx = ST_IDLE;
            if (req) begin
               lwr_nx    = wr;
               laddr_nx  = addr;
               lwdata_nx = wdata;
               cnt_nx    = WS;
               if (WS == 4'd0) begin
                  // Zero wait states complete at the accepting edge, so the
                  // access is taken straight from the bus, not the latches.
                  state_nx   = ST_DONE;
                  enter_done = 1'b1;
                  acc_wr     = wr;
                  acc_addr   = addr;
                  acc_wdata  = wdata;
               end else begin
                  state_nx = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_nx = cnt - 4'd1;
            if (cnt <= 4'd1) begin
               state_nx   = ST_DONE;
               enter_done = 1'b1;
               cnt_nx     = '0;
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      acc_in_range = ({1'b0, acc_addr} < LIMIT);
      ld_in_range  = ({1'b0, ld_addr} < LIMIT);
      acc_idx      = acc_addr[IDX_W-1:0];

      err_nx   = 1'b0;
      rdata_nx = rdata;
      if (enter_done) begin
         err_nx = !acc_in_range;
         if (!acc_in_range) begin
            rdata_nx = '0;
         end else if (acc_wr) begin
            rdata_nx = acc_wdata;
         end else begin
            rdata_nx = mem[acc_idx];
         end
      end

      // Bus writes and preloads never coincide: preload needs IDLE with req low.
      mem_we  = 1'b0;
      mem_idx = acc_idx;
      mem_wd  = acc_wdata;
      if (enter_done && acc_wr && acc_in_range) begin
         mem_we = 1'b1;
      end else if ((state == ST_IDLE) && !req && ld_en && ld_in_range) begin
         mem_we  = 1'b1;
         mem_idx = ld_addr[IDX_W-1:0];
         mem_wd  = ld_data;
      end
   end

   // Control state, latched request and registered completion outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         lwr    <= 1'b0;
         laddr  <= '0;
         lwdata <= '0;
         rdata  <= '0;
         err    <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         lwr    <= lwr_nx;
         laddr  <= laddr_nx;
         lwdata <= lwdata_nx;
         rdata  <= rdata_nx;
         err    <= err_nx;
      end
   end

   // Storage array; deliberately not reset so contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= mem_wd;
      end
   end

endmodule

// File: tb/tb_bus_mem.sv
// tb_bus_mem: three bus_mem instances (WAIT_STATES 1, 0, 3) driven by
// directed and random accesses, checked against an array reference model.
module tb_bus_mem;

   localparam int DEPTH = 38;

   logic              clk   = 1'b0;
   logic              reset = 1'b1;
   logic [2:0]        req_v, wr_v, ld_en_v;
   logic [2:0][15:0]  addr_v, wdata_v, ld_addr_v, ld_data_v;
   logic [2:0][15:0]  rdata_v;
   logic [2:0]        ready_v, err_v, busy_v;

   int          tests_run = 0;
   int          fails     = 0;
   logic [15:0] mdl [3][DEPTH];

   always #5 clk = ~clk;

   bus_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_STATES(1)) u_w1 (
      .clk(clk), .reset(reset), .req(req_v[0]), .wr(wr_v[0]), .addr(addr_v[0]),
      .wdata(wdata_v[0]), .rdata(rdata_v[0]), .ready(ready_v[0]), .err(err_v[0]),
      .busy(busy_v[0]), .ld_en(ld_en_v[0]), .ld_addr(ld_addr_v[0]), .ld_data(ld_data_v[0]));

   bus_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_STATES(0)) u_w0 (
      .clk(clk), .reset(reset), .req(req_v[1]), .wr(wr_v[1]), .addr(addr_v[1]),
      .wdata(wdata_v[1]), .rdata(rdata_v[1]), .ready(ready_v[1]), .err(err_v[1]),
      .busy(busy_v[1]), .ld_en(ld_en_v[1]), .ld_addr(ld_addr_v[1]), .ld_data(ld_data_v[1]));

   bus_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .WAIT_STATES(3)) u_w3 (
      .clk(clk), .reset(reset), .req(req_v[2]), .wr(wr_v[2]), .addr(addr_v[2]),
      .wdata(wdata_v[2]), .rdata(rdata_v[2]), .ready(ready_v[2]), .err(err_v[2]),
      .busy(busy_v[2]), .ld_en(ld_en_v[2]), .ld_addr(ld_addr_v[2]), .ld_data(ld_data_v[2]));

   function automatic int ws_of(input int s);
      return (s == 0) ? 1 : ((s == 1) ? 0 : 3);
   endfunction

   // Reference model: applies one access to the model array, returns expected outputs.
   task automatic model_apply(input int s, input bit w, input logic [15:0] a,
                              input logic [15:0] d, output logic [15:0] er, output logic ee);
      if (int'(a) >= DEPTH) begin
         er = '0;
         ee = 1'b1;
      end else if (w) begin
         mdl[s][int'(a)] = d;
         er = d;
         ee = 1'b0;
      end else begin
         er = mdl[s][int'(a)];
         ee = 1'b0;
      end
   endtask

   // Single access. lat = posedges after the accepting edge before ready is
   // visible (ready is then sampled by edge accept+1+lat). Bus fields are
   // scrambled right after acceptance.
   task automatic run_access(input int s, input bit w, input logic [15:0] a, input logic [15:0] d,
                             output logic [15:0] rd, output logic e, output int lat,
                             output int bcnt, output bit to);
      @(negedge clk);
      req_v[s] = 1'b1; wr_v[s] = w; addr_v[s] = a; wdata_v[s] = d;
      @(posedge clk);
      @(negedge clk);
      req_v[s] = 1'b0; wr_v[s] = 1'($urandom); addr_v[s] = 16'($urandom); wdata_v[s] = 16'($urandom);
      lat = 0; bcnt = 0; to = 1'b1; rd = '0; e = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (busy_v[s]) bcnt++;
         if (ready_v[s]) begin
            rd = rdata_v[s]; e = err_v[s]; to = 1'b0;
            break;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   // Two accesses with req held high; gap = cycles between the two ready pulses.
   task automatic run_b2b(input int s, input bit w1, input logic [15:0] a1, input logic [15:0] d1,
                          input bit w2, input logic [15:0] a2, input logic [15:0] d2,
                          output logic [15:0] rd1, output logic e1,
                          output logic [15:0] rd2, output logic e2, output int gap, output bit to);
      int p1;
      bit seen, drop;
      @(negedge clk);
      req_v[s] = 1'b1; wr_v[s] = w1; addr_v[s] = a1; wdata_v[s] = d1;
      @(posedge clk);
      @(negedge clk);
      wr_v[s] = w2; addr_v[s] = a2; wdata_v[s] = d2;
      seen = 1'b0; drop = 1'b0; to = 1'b1; p1 = 0; gap = -1;
      rd1 = '0; rd2 = '0; e1 = 1'b0; e2 = 1'b0;
      for (int n = 0; n < 80; n++) begin
         if (drop) begin
            req_v[s] = 1'b0; addr_v[s] = 16'($urandom); wdata_v[s] = 16'($urandom);
            drop = 1'b0;
         end
         if (ready_v[s]) begin
            if (!seen) begin
               rd1 = rdata_v[s]; e1 = err_v[s]; p1 = n; seen = 1'b1; drop = 1'b1;
            end else begin
               rd2 = rdata_v[s]; e2 = err_v[s]; gap = n - p1; to = 1'b0;
               break;
            end
         end
         @(negedge clk);
      end
      req_v[s] = 1'b0;
   endtask

   task automatic test_reset();
      req_v = '0; wr_v = '0; ld_en_v = '0; addr_v = '0; wdata_v = '0; ld_addr_v = '0; ld_data_v = '0;
      #1 reset = 1'b0;
      #200;
      for (int s = 0; s < 3; s++) begin
         tests_run++;
         if (ready_v[s] !== 1'b0) begin fails++; $display("FAIL reset_ready[%0d]: got %b expected 0", s, ready_v[s]); end
         tests_run++;
         if (err_v[s] !== 1'b0) begin fails++; $display("FAIL reset_err[%0d]: got %b expected 0", s, err_v[s]); end
         tests_run++;
         if (busy_v[s] !== 1'b0) begin fails++; $display("FAIL reset_busy[%0d]: got %b expected 0", s, busy_v[s]); end
         tests_run++;
         if (rdata_v[s] !== 16'h0000) begin fails++; $display("FAIL reset_rdata[%0d]: got %h expected 0000", s, rdata_v[s]); end
      end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_preload_init();
      logic [15:0] rd, er;
      logic        e, ee;
      int          lat, bc;
      bit          to;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         for (int s = 0; s < 3; s++) begin
            ld_en_v[s] = 1'b1; ld_addr_v[s] = 16'(i); ld_data_v[s] = 16'($urandom);
            mdl[s][i] = ld_data_v[s];
         end
      end
      @(negedge clk);
      ld_en_v[0] = 1'b1; ld_addr_v[0] = 16'd0; ld_data_v[0] = 16'h81F0; mdl[0][0] = 16'h81F0;
      ld_en_v[1] = 1'b0; ld_en_v[2] = 1'b0;
      @(negedge clk);
      ld_en_v[0] = 1'b1; ld_addr_v[0] = 16'd1; ld_data_v[0] = 16'h01FF; mdl[0][1] = 16'h01FF;
      @(negedge clk);
      ld_en_v = '0;
      for (int a = 0; a < 2; a++) begin
         model_apply(0, 1'b0, 16'(a), 16'h0, er, ee);
         run_access(0, 1'b0, 16'(a), 16'h0, rd, e, lat, bc, to);
         tests_run++;
         if (to) begin fails++; $display("FAIL preload_timeout addr %0d: got no ready expected ready", a); end
         tests_run++;
         if (lat != 1) begin fails++; $display("FAIL preload_latency addr %0d: got %0d expected 1", a, lat); end
         tests_run++;
         if (rd !== er) begin fails++; $display("FAIL preload_rdata addr %0d: got %h expected %h", a, rd, er); end
         tests_run++;
         if (e !== 1'b0) begin fails++; $display("FAIL preload_err addr %0d: got %b expected 0", a, e); end
      end
   endtask

   task automatic test_latency();
      logic [15:0] rd, er;
      logic        e, ee;
      int          lat, bc;
      bit          to;
      for (int s = 1; s < 3; s++) begin
         model_apply(s, 1'b0, 16'd1, 16'h0, er, ee);
         run_access(s, 1'b0, 16'd1, 16'h0, rd, e, lat, bc, to);
         tests_run++;
         if (to || lat != ws_of(s)) begin fails++; $display("FAIL latency[%0d]: got %0d expected %0d", s, lat, ws_of(s)); end
         tests_run++;
         if (bc != ws_of(s) + 1) begin fails++; $display("FAIL busy_cycles[%0d]: got %0d expected %0d", s, bc, ws_of(s) + 1); end
         tests_run++;
         if (rd !== er || e !== ee) begin fails++; $display("FAIL latency_rdata[%0d]: got %h/%b expected %h/%b", s, rd, e, er, ee); end
         @(negedge clk);
         tests_run++;
         if (ready_v[s] !== 1'b0 || busy_v[s] !== 1'b0) begin
            fails++; $display("FAIL ready_pulse[%0d]: got ready %b busy %b expected 0 0", s, ready_v[s], busy_v[s]);
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] rd, er, a, d;
      logic        e, ee;
      bit          w, to;
      int          lat, bc;
      for (int s = 0; s < 3; s++) begin
         for (int i = 0; i < 25; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 45));
            d = 16'($urandom);
            model_apply(s, w, a, d, er, ee);
            run_access(s, w, a, d, rd, e, lat, bc, to);
            tests_run++;
            if (to || rd !== er || e !== ee || lat != ws_of(s)) begin
               fails++;
               $display("FAIL random[%0d] wr %b addr %0d: got %h/%b lat %0d expected %h/%b lat %0d",
                        s, w, a, rd, e, lat, er, ee, ws_of(s));
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] rd1, rd2, er1, er2, er, rd, a1, a2, d1, d2;
      logic        e1, e2, ee1, ee2, ee, e;
      bit          w1, w2, to;
      int          gap, lat, bc;
      for (int s = 0; s < 3; s++) begin
         model_apply(s, 1'b1, 16'd5, 16'hA5A5, er1, ee1);
         model_apply(s, 1'b0, 16'd5, 16'h0, er2, ee2);
         run_b2b(s, 1'b1, 16'd5, 16'hA5A5, 1'b0, 16'd5, 16'h0, rd1, e1, rd2, e2, gap, to);
         tests_run++;
         if (to || gap != ws_of(s) + 1) begin fails++; $display("FAIL b2b_gap[%0d]: got %0d expected %0d", s, gap, ws_of(s) + 1); end
         tests_run++;
         if (rd1 !== 16'hA5A5 || e1 !== 1'b0) begin fails++; $display("FAIL b2b_write_echo[%0d]: got %h/%b expected a5a5/0", s, rd1, e1); end
         tests_run++;
         if (rd2 !== er2 || e2 !== 1'b0) begin fails++; $display("FAIL b2b_raw[%0d]: got %h/%b expected %h/0", s, rd2, e2, er2); end
         for (int a = 4; a <= 6; a += 2) begin
            model_apply(s, 1'b0, 16'(a), 16'h0, er, ee);
            run_access(s, 1'b0, 16'(a), 16'h0, rd, e, lat, bc, to);
            tests_run++;
            if (to || rd !== er) begin fails++; $display("FAIL b2b_neighbour[%0d] addr %0d: got %h expected %h", s, a, rd, er); end
         end
         for (int i = 0; i < 8; i++) begin
            w1 = 1'($urandom_range(0, 1)); a1 = 16'($urandom_range(0, 41)); d1 = 16'($urandom);
            w2 = 1'($urandom_range(0, 1)); d2 = 16'($urandom);
            a2 = (i % 2 == 0) ? a1 : 16'($urandom_range(0, 41));
            model_apply(s, w1, a1, d1, er1, ee1);
            model_apply(s, w2, a2, d2, er2, ee2);
            run_b2b(s, w1, a1, d1, w2, a2, d2, rd1, e1, rd2, e2, gap, to);
            tests_run++;
            if (to || rd1 !== er1 || e1 !== ee1 || rd2 !== er2 || e2 !== ee2 || gap != ws_of(s) + 1) begin
               fails++;
               $display("FAIL b2b_random[%0d]: got %h/%b %h/%b gap %0d expected %h/%b %h/%b gap %0d",
                        s, rd1, e1, rd2, e2, gap, er1, ee1, er2, ee2, ws_of(s) + 1);
            end
         end
      end
   endtask

   task automatic test_out_of_range();
      logic [15:0] rd, er;
      logic        e, ee;
      int          lat, bc;
      bit          to;
      model_apply(0, 1'b0, 16'd38, 16'h0, er, ee);
      run_access(0, 1'b0, 16'd38, 16'h0, rd, e, lat, bc, to);
      tests_run++;
      if (to || e !== 1'b1 || rd !== 16'h0000) begin fails++; $display("FAIL oor_read: got %h/%b expected 0000/1", rd, e); end
      model_apply(0, 1'b1, 16'd40, 16'hFFFF, er, ee);
      run_access(0, 1'b1, 16'd40, 16'hFFFF, rd, e, lat, bc, to);
      tests_run++;
      if (to || e !== 1'b1 || rd !== 16'h0000) begin fails++; $display("FAIL oor_write: got %h/%b expected 0000/1", rd, e); end
      @(negedge clk);
      ld_en_v[0] = 1'b1; ld_addr_v[0] = 16'd38; ld_data_v[0] = 16'hDEAD;
      @(negedge clk);
      ld_addr_v[0] = 16'hFFFF;
      @(negedge clk);
      ld_en_v[0] = 1'b0;
      for (int a = 0; a < DEPTH; a++) begin
         model_apply(0, 1'b0, 16'(a), 16'h0, er, ee);
         run_access(0, 1'b0, 16'(a), 16'h0, rd, e, lat, bc, to);
         tests_run++;
         if (to || rd !== er || e !== 1'b0) begin fails++; $display("FAIL oor_scan addr %0d: got %h/%b expected %h/0", a, rd, e, er); end
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] rd, er, oldv;
      logic        e, ee;
      int          lat, bc;
      bit          to;
      oldv = mdl[2][2];
      @(negedge clk);
      req_v[2] = 1'b1; wr_v[2] = 1'b1; addr_v[2] = 16'd2; wdata_v[2] = ~oldv;
      @(posedge clk);
      @(negedge clk);
      req_v[2] = 1'b0;
      tests_run++;
      if (busy_v[2] !== 1'b1) begin fails++; $display("FAIL midreset_busy_before: got %b expected 1", busy_v[2]); end
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      tests_run++;
      if (busy_v[2] !== 1'b0 || ready_v[2] !== 1'b0 || err_v[2] !== 1'b0 || rdata_v[2] !== 16'h0000) begin
         fails++;
         $display("FAIL midreset_outputs: got busy %b ready %b err %b rdata %h expected 0 0 0 0000",
                  busy_v[2], ready_v[2], err_v[2], rdata_v[2]);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      model_apply(2, 1'b0, 16'd2, 16'h0, er, ee);
      run_access(2, 1'b0, 16'd2, 16'h0, rd, e, lat, bc, to);
      tests_run++;
      if (to || rd !== oldv) begin fails++; $display("FAIL midreset_retained: got %h expected %h", rd, oldv); end
   endtask

   task automatic test_preload_block();
      logic [15:0] rd, er, newv;
      logic        e, ee;
      int          lat, bc;
      bit          to, seen;
      newv = ~mdl[2][7];
      // ld_en held through WAIT and DONE of an access
      @(negedge clk);
      req_v[2] = 1'b1; wr_v[2] = 1'b0; addr_v[2] = 16'd10;
      @(posedge clk);
      @(negedge clk);
      req_v[2] = 1'b0; ld_en_v[2] = 1'b1; ld_addr_v[2] = 16'd7; ld_data_v[2] = newv;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (ready_v[2]) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      ld_en_v[2] = 1'b0;
      tests_run++;
      if (!seen) begin fails++; $display("FAIL ldblock_busy_timeout: got no ready expected ready"); end
      model_apply(2, 1'b0, 16'd7, 16'h0, er, ee);
      run_access(2, 1'b0, 16'd7, 16'h0, rd, e, lat, bc, to);
      tests_run++;
      if (to || rd !== er) begin fails++; $display("FAIL ldblock_busy: got %h expected %h", rd, er); end
      // ld_en together with req
      @(negedge clk);
      req_v[2] = 1'b1; wr_v[2] = 1'b0; addr_v[2] = 16'd9;
      ld_en_v[2] = 1'b1; ld_addr_v[2] = 16'd7; ld_data_v[2] = newv;
      @(posedge clk);
      @(negedge clk);
      req_v[2] = 1'b0; ld_en_v[2] = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (ready_v[2]) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      tests_run++;
      if (!seen) begin fails++; $display("FAIL ldblock_req_timeout: got no ready expected ready"); end
      model_apply(2, 1'b0, 16'd7, 16'h0, er, ee);
      run_access(2, 1'b0, 16'd7, 16'h0, rd, e, lat, bc, to);
      tests_run++;
      if (to || rd !== er) begin fails++; $display("FAIL ldblock_req: got %h expected %h", rd, er); end
      // same preload in IDLE with req low
      @(negedge clk);
      ld_en_v[2] = 1'b1; ld_addr_v[2] = 16'd7; ld_data_v[2] = newv;
      mdl[2][7] = newv;
      @(negedge clk);
      ld_en_v[2] = 1'b0;
      model_apply(2, 1'b0, 16'd7, 16'h0, er, ee);
      run_access(2, 1'b0, 16'd7, 16'h0, rd, e, lat, bc, to);
      tests_run++;
      if (to || rd !== newv) begin fails++; $display("FAIL ldblock_idle: got %h expected %h", rd, newv); end
   endtask

   initial begin
      test_reset();
      test_preload_init();
      test_latency();
      test_random();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid();
      test_preload_block();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/bus_mem.md
# bus_mem

Parametrised word-addressed memory with programmable wait states, serving the cpu0 address/data bus. It replaces the flat combinational program-ROM vector used in simulation: it adds write support, a req/ready handshake with WAIT_STATES latency, an out-of-range error flag and a preload port. It sits between cpu0 (or a bus arbiter) and the bench, and is synthesizable as a register-array memory.

## Interface
- DATA_W, 16, data word width in bits
- ADDR_W, 16, address width (word address)
- DEPTH, 38, number of implemented words; valid addresses 0..DEPTH-1
- WAIT_STATES, 1, extra cycles inserted per access (0..15)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- req  input  1  access request; sampled on rising edge when accept is possible
- wr  input  1  1 = write, 0 = read; sampled with req
- addr  input  ADDR_W  word address; sampled with req
- wdata  input  DATA_W  write data; sampled with req
- rdata  output  DATA_W  read data; valid while ready=1
- ready  output  1  one-cycle completion pulse
- err  output  1  high with ready when the completed access was out of range
- busy  output  1  high while an accepted access is in flight (WAIT or DONE state)
- ld_en  input  1  preload write strobe
- ld_addr  input  ADDR_W  preload address
- ld_data  input  DATA_W  preload data

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state IDLE.
- Accept: req=1 at a rising edge while state is IDLE or DONE. Latch wr, addr, wdata; load wait counter with WAIT_STATES.
- Accept transition: to WAIT if WAIT_STATES>0, else directly to DONE.
- WAIT: counter decrements each cycle; when it reaches 0, go to DONE. req ignored in WAIT.
- DONE: ready=1 for exactly this cycle. Next state: WAIT/DONE if req=1 (new accept), else IDLE.
- Read: rdata = mem[latched addr], registered on entry to DONE.
- Write: mem[latched addr] <= latched wdata on entry to DONE; rdata also shows the written value.
- Out of range (latched addr >= DEPTH): err=1 with ready, rdata=0, write discarded, no other array word disturbed.
- err is 0 whenever ready=0.
- Preload: ld_en honoured only in IDLE with req=0; writes mem[ld_addr] <= ld_data at that edge. Ignored if ld_addr >= DEPTH. Ignored in WAIT/DONE, or when req=1 (req has priority).
- Memory array is not cleared by reset; contents persist across reset.

## Timing
- Reset values: ready=0, err=0, busy=0, rdata=0, state IDLE, counter 0.
- Latency: req accepted at edge N -> ready high from edge N+1+WAIT_STATES for one cycle.
- Back-to-back: req held high issues one access every WAIT_STATES+1 cycles (WAIT_STATES=0: one access per cycle, ready continuously high).
- Read-after-write to same address, back-to-back: the read returns the newly written value.
- busy high from edge N+1 through the DONE cycle; low in IDLE.
- Reset asserted mid-access: asynchronously forces IDLE, ready=0, err=0, busy=0, rdata=0; an in-flight write not yet in DONE is dropped.
- Changes to addr/wr/wdata after acceptance have no effect on the access.

## Test plan
- Reset and preload, WAIT_STATES=1: hold reset low 200 ns -> ready/err/busy/rdata all 0. Then preload mem[0]=16'h81F0 and mem[1]=16'h01FF, read addr 0 -> ready exactly 2 edges after accept, rdata=16'h81F0, err=0.
- Latency sweep: WAIT_STATES=0 and 3, single read of addr 1 -> ready at edge N+1 and edge N+4 respectively. busy high over 1 and 4 cycles respectively.
- Write/read: write 16'hA5A5 to addr 5, immediately followed by back-to-back read of addr 5 -> second ready shows rdata=16'hA5A5. Addr 4 and 6 unchanged.
- Out of range, DEPTH=38: read addr 38 -> ready=1, err=1, rdata=0. Write 16'hFFFF to addr 40 -> err=1, all 38 words unchanged.
- Reset mid-access, WAIT_STATES=3: accept write to addr 2, assert reset during WAIT -> outputs return to 0 immediately. mem[2] retains its old value. After release, read addr 2 returns the old value.
- Preload blocking: ld_en=1 while busy, or together with req=1 -> target word unchanged. The same ld_en in IDLE with req=0 -> word updated.
